// File: rtl/bcd_display_scan.sv
// bcd_display_scan: captures a packed 2-digit BCD word and drives a
// time-multiplexed 2-digit 7-segment display with registered outputs.
//
// state   | meaning
// --------+---------------------------------------------
// S_UNITS | units digit (an[0]) is being driven
// S_TENS  | tens digit (an[1]) is being driven or blanked
module bcd_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_bcd_in,
  input  logic       i_bcd_valid,
  input  logic       i_blank_lz,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_frame_done,
  output logic       o_bcd_err
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [0:0] S_UNITS = 1'b0;
  localparam logic [0:0] S_TENS  = 1'b1;

  // All-off patterns in the board polarity
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [7:0]       r_value;
  logic             r_err;
  logic [DIV_W-1:0] r_div_cnt;
  logic [0:0]       r_state;
  logic             r_frame_done;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;

  logic             w_wrap;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg_hi;
  logic [1:0]       w_an_hi;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  assign w_wrap = (r_div_cnt == DIV_LAST);

  // Capture register and non-BCD flag, both updated only on a valid strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= 8'h00;
      r_err   <= 1'b0;
    end else if (i_bcd_valid) begin
      r_value <= i_bcd_in;
      r_err   <= (i_bcd_in[7:4] > 4'd9) | (i_bcd_in[3:0] > 4'd9);
    end
  end

  // Refresh divider: counts 0..REFRESH_DIV-1 and wraps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Scan FSM: toggles digit on each divider wrap; end of tens slot closes a frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_UNITS;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_wrap) begin
        case (r_state)
          S_UNITS: r_state <= S_TENS;
          default: begin
            r_state      <= S_UNITS;
            r_frame_done <= 1'b1;
          end
        endcase
      end
    end
  end

  // Digit select, leading-zero blanking and decode in active-high form
  always_comb begin
    w_digit  = (r_state == S_TENS) ? r_value[7:4] : r_value[3:0];
    w_blank  = (r_state == S_TENS) && i_blank_lz && (r_value[7:4] == 4'd0);
    w_seg_hi = 7'h00;
    w_an_hi  = 2'b00;
    if (!w_blank) begin
      w_seg_hi = seg_decode(w_digit);
      w_an_hi  = (r_state == S_TENS) ? 2'b10 : 2'b01;
    end
  end

  // Registered output stage with board polarity applied
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
      r_an  <= ACTIVE_LOW ? ~w_an_hi  : w_an_hi;
    end
  end

  assign o_seg        = r_seg;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;
  assign o_bcd_err    = r_err;

endmodule
